div_seq_param: RTL and testbench

//  Parametrised multi-cycle integer divider for the MultDiv unit: WIDTH-bit dividend/divisor,

---
 rtl/div_seq_param_if.sv | 24 ++
 rtl/div_seq_param.sv | 109 ++++++++++
 tb/tb_div_seq_param.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/div_seq_param_if.sv
// Start/busy/done handshake and operand/result bus between the MultDiv control FSM and the divider.
interface div_seq_param_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             div_signed;
    logic [WIDTH-1:0] regA_out;
    logic [WIDTH-1:0] regB_out;
    logic             busy;
    logic             done;
    logic             zeroDiv;
    logic [WIDTH-1:0] hi_entrance;
    logic [WIDTH-1:0] lo_entrance;

    modport master (
        output start, div_signed, regA_out, regB_out,
        input  busy, done, zeroDiv, hi_entrance, lo_entrance
    );

    modport slave (
        input  start, div_signed, regA_out, regB_out,
        output busy, done, zeroDiv, hi_entrance, lo_entrance
    );
endinterface

// File: rtl/div_seq_param.sv
// Restoring shift-subtract divider, one quotient bit per cycle on operand magnitudes,
// with a final cycle that restores the signs: remainder to HI, quotient to LO.
module div_seq_param #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] ZDIV_VALUE = WIDTH'(32'h7FFFFFFF)
) (
    input  logic            clock,
    input  logic            reset,
    div_seq_param_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_n;
    logic             sa, sb, zflag;
    logic [WIDTH-1:0] babs, quo;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;
    logic             busy_q, done_q, zdiv_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             sa_in, sb_in;
    logic [WIDTH-1:0] aabs_in, babs_in;
    logic [WIDTH:0]   t, rem_n;
    logic             ge;

    assign sa_in   = bus.div_signed & bus.regA_out[WIDTH-1];
    assign sb_in   = bus.div_signed & bus.regB_out[WIDTH-1];
    assign aabs_in = sa_in ? -bus.regA_out : bus.regA_out;
    assign babs_in = sb_in ? -bus.regB_out : bus.regB_out;

    // One restoring step: shift the next dividend bit into the partial remainder.
    always_comb begin
        t     = {rem[WIDTH-1:0], quo[WIDTH-1]};
        ge    = (t >= {1'b0, babs});
        rem_n = ge ? (t - {1'b0, babs}) : t;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (bus.start) state_n = (babs_in == '0) ? FIX : RUN;
            RUN:  if (cnt == CW'(1)) state_n = FIX;
            FIX:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            sa     <= 1'b0;
            sb     <= 1'b0;
            zflag  <= 1'b0;
            babs   <= '0;
            quo    <= '0;
            rem    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            zdiv_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            state  <= state_n;
            busy_q <= (state_n == RUN);
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    zdiv_q <= 1'b0;
                    hi_q   <= '0;
                    lo_q   <= '0;
                    sa     <= sa_in;
                    sb     <= sb_in;
                    babs   <= babs_in;
                    quo    <= aabs_in;
                    rem    <= '0;
                    cnt    <= CW'(WIDTH);
                    zflag  <= (babs_in == '0);
                end
                RUN: begin
                    rem <= rem_n;
                    quo <= {quo[WIDTH-2:0], ge};
                    cnt <= cnt - CW'(1);
                end
                FIX: begin
                    if (zflag) begin
                        hi_q   <= ZDIV_VALUE;
                        lo_q   <= ZDIV_VALUE;
                        zdiv_q <= 1'b1;
                    end else begin
                        // Quotient truncates toward zero; remainder takes the dividend's sign.
                        lo_q <= (sa ^ sb) ? -quo : quo;
                        hi_q <= sa ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.zeroDiv     = zdiv_q;
    assign bus.hi_entrance = hi_q;
    assign bus.lo_entrance = lo_q;
endmodule

// File: tb/tb_div_seq_param.sv
// Random and directed divisions on a 32-bit and an 8-bit divider, checked against integer arithmetic.
module tb_div_seq_param;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errs = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    div_seq_param_if #(.WIDTH(32)) if32 ();
    div_seq_param_if #(.WIDTH(8))  if8 ();

    div_seq_param #(.WIDTH(32), .ZDIV_VALUE(32'h7FFFFFFF)) u_div32 (
        .clock(clock), .reset(reset), .bus(if32));
    div_seq_param #(.WIDTH(8), .ZDIV_VALUE(8'h7F)) u_div8 (
        .clock(clock), .reset(reset), .bus(if8));

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: signed/unsigned integer division on wide integers, truncated to w bits.
    function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic s, output logic [31:0] q, output logic [31:0] r,
                                  output logic z);
        longint m, x, y;
        m = (longint'(1) << w) - 1;
        x = longint'(a) & m;
        y = longint'(b) & m;
        if (s && x[w-1]) x = x - (longint'(1) << w);
        if (s && y[w-1]) y = y - (longint'(1) << w);
        if (y == 0) begin
            z = 1'b1;
            q = (w == 32) ? 32'h7FFFFFFF : 32'h7F;
            r = q;
        end else begin
            z = 1'b0;
            q = 32'((x / y) & m);
            r = 32'((x % y) & m);
        end
    endfunction

    task automatic set_in(input int w, input logic st, input logic s,
                          input logic [31:0] a, input logic [31:0] b);
        if (w == 32) begin
            if32.start = st; if32.div_signed = s; if32.regA_out = a; if32.regB_out = b;
        end else begin
            if8.start = st; if8.div_signed = s; if8.regA_out = a[7:0]; if8.regB_out = b[7:0];
        end
    endtask

    task automatic set_start(input int w, input logic st);
        if (w == 32) if32.start = st; else if8.start = st;
    endtask

    function automatic logic get_done(input int w);
        return (w == 32) ? if32.done : if8.done;
    endfunction
    function automatic logic get_busy(input int w);
        return (w == 32) ? if32.busy : if8.busy;
    endfunction
    function automatic logic get_zd(input int w);
        return (w == 32) ? if32.zeroDiv : if8.zeroDiv;
    endfunction
    function automatic logic [31:0] get_lo(input int w);
        return (w == 32) ? if32.lo_entrance : {24'h0, if8.lo_entrance};
    endfunction
    function automatic logic [31:0] get_hi(input int w);
        return (w == 32) ? if32.hi_entrance : {24'h0, if8.hi_entrance};
    endfunction

    // One division: accept, scramble operands and pulse start while busy, then check result.
    task automatic op(input int w, input logic s, input logic [31:0] a, input logic [31:0] b,
                      input string tag);
        logic [31:0] eq, er;
        logic        ez;
        int          cyc, bcnt;
        model(w, a, b, s, eq, er, ez);
        @(negedge clock);
        set_in(w, 1'b1, s, a, b);
        @(posedge clock); #1;
        set_in(w, 1'b0, 1'($urandom), $urandom, $urandom);
        cyc = 0;
        bcnt = 0;
        while (!get_done(w) && cyc < 200) begin
            bcnt += int'(get_busy(w));
            set_start(w, (cyc < w) ? 1'($urandom_range(0, 1)) : 1'b0);
            @(posedge clock); #1;
            cyc++;
        end
        set_start(w, 1'b0);
        chk({tag, " latency"}, 64'(cyc), ez ? 64'd1 : 64'(w + 1));
        chk({tag, " lo"}, 64'(get_lo(w)), 64'(eq));
        chk({tag, " hi"}, 64'(get_hi(w)), 64'(er));
        chk({tag, " zeroDiv"}, 64'(get_zd(w)), 64'(ez));
        chk({tag, " busy cycles"}, 64'(bcnt), ez ? 64'd0 : 64'(w));
    endtask

    initial begin
        int cyc;
        logic [31:0] ra, rb;
        set_in(32, 1'b0, 1'b0, '0, '0);
        set_in(8, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clock);
        #1;
        chk("reset busy", 64'(if32.busy), 64'd0);
        chk("reset done", 64'(if32.done), 64'd0);
        chk("reset zeroDiv", 64'(if32.zeroDiv), 64'd0);
        chk("reset hi", 64'(if32.hi_entrance), 64'd0);
        chk("reset lo", 64'(if32.lo_entrance), 64'd0);
        chk("reset lo8", 64'(if8.lo_entrance), 64'd0);
        reset = 1'b0;

        op(32, 1'b0, 32'd7, 32'd2, "u 7/2");
        op(32, 1'b1, 32'hFFFFFFF9, 32'd2, "s -7/2");
        op(32, 1'b1, 32'd7, 32'hFFFFFFFE, "s 7/-2");
        op(32, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, "s -7/-2");
        op(32, 1'b0, 32'd5, 32'd0, "u 5/0");
        op(32, 1'b1, 32'd5, 32'd0, "s 5/0");
        op(32, 1'b0, 32'd9, 32'd3, "u 9/3");
        op(32, 1'b0, 32'hFFFFFFFF, 32'd1, "u max/1");
        op(32, 1'b1, 32'h80000000, 32'hFFFFFFFF, "s min/-1");
        op(32, 1'b0, 32'h80000000, 32'hFFFFFFFF, "u 8000/ffff");
        op(8, 1'b0, 32'd200, 32'd7, "w8 u 200/7");
        op(8, 1'b1, 32'h80, 32'd3, "w8 s -128/3");
        op(8, 1'b0, 32'd5, 32'd0, "w8 5/0");

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = (i % 4 == 3) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            if (i % 3 == 0) rb = -rb;
            op(32, 1'($urandom), ra, rb, $sformatf("rand32 %0d", i));
            op(8, 1'($urandom), ra, rb, $sformatf("rand8 %0d", i));
        end

        // Abort a division with reset ten cycles after accept.
        @(negedge clock);
        set_in(32, 1'b1, 1'b0, 32'd1000, 32'd7);
        @(posedge clock); #1;
        set_start(32, 1'b0);
        repeat (9) begin
            @(posedge clock); #1;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort busy", 64'(if32.busy), 64'd0);
        chk("abort hi", 64'(if32.hi_entrance), 64'd0);
        chk("abort lo", 64'(if32.lo_entrance), 64'd0);
        chk("abort done", 64'(if32.done), 64'd0);
        cyc = 0;
        repeat (50) begin
            @(posedge clock); #1;
            if (if32.done) cyc++;
        end
        chk("abort no done later", 64'(cyc), 64'd0);
        op(32, 1'b1, 32'hFFFFFF9C, 32'd7, "after abort -100/7");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
